// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct constants and the multiply/divide sequencer state type.
// Revision: 1.0
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_ADDIU = 6'h09;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADDU   = 6'h21;
  localparam logic [5:0] FUNCT_MFHI   = 6'h10;
  localparam logic [5:0] FUNCT_MTHI   = 6'h11;
  localparam logic [5:0] FUNCT_MFLO   = 6'h12;
  localparam logic [5:0] FUNCT_MTLO   = 6'h13;
  localparam logic [5:0] FUNCT_MULT   = 6'h18;
  localparam logic [5:0] FUNCT_MULTU  = 6'h19;
  localparam logic [5:0] FUNCT_DIV    = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU   = 6'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on unsigned magnitudes.
// Revision: 1.0
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] mq_in,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] mq_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_in} + (mq_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = {acc_in, mq_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, opnd});
    // Partial remainder is always below the divisor, so the difference fits WIDTH bits.
    diff    = shifted[WIDTH-1:0] - opnd;
    if (div_mode) begin
      acc_out = fits ? diff : shifted[WIDTH-1:0];
      mq_out  = {mq_in[WIDTH-2:0], fits};
    end else begin
      acc_out = sum[WIDTH:1];
      mq_out  = {sum[0], mq_in[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; MTHI/MTLO write in one cycle.
// Revision: 1.0 -- MIPS_MULDIV_FAST_MULT_EN selects a single-cycle multiplier for MULT/MULTU.
`default_nettype none

module mips_muldiv_unit #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [5:0]       fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mips_pkg::*;

  localparam int N  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  muldiv_state_t    state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opnd;
  logic             div_mode;
  logic             neg_main;
  logic             neg_rem;

  logic             is_mul;
  logic             is_div;
  logic             is_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  logic [WIDTH-1:0] acc_chain [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0] mq_chain  [STEPS_PER_CYCLE+1];

  assign busy = (state != IDLE);

  always_comb begin
    is_mul    = (fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU);
    is_div    = (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU);
    is_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
    sign_a    = is_signed && op_a[WIDTH-1];
    sign_b    = is_signed && op_b[WIDTH-1];
    mag_a     = sign_a ? (~op_a + 1'b1) : op_a;
    mag_b     = sign_b ? (~op_b + 1'b1) : op_b;
  end

  assign acc_chain[0] = acc;
  assign mq_chain[0]  = mq;

  generate
    for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
      muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (div_mode),
        .opnd     (opnd),
        .acc_in   (acc_chain[i]),
        .mq_in    (mq_chain[i]),
        .acc_out  (acc_chain[i+1]),
        .mq_out   (mq_chain[i+1])
      );
    end
  endgenerate

`ifdef MIPS_MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  // Sign correction applied only on the FIXUP edge, so hi/lo never see magnitudes.
  always_comb begin
    prod = neg_main ? (~{acc, mq} + 1'b1) : {acc, mq};
    quot = neg_main ? (~mq + 1'b1) : mq;
    rem  = neg_rem  ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (fncode == FUNCT_MTHI) begin
              hi <= op_a;
            end else if (fncode == FUNCT_MTLO) begin
              lo <= op_a;
            end else if (is_mul || is_div) begin
              acc      <= '0;
              mq       <= mag_a;
              opnd     <= mag_b;
              div_mode <= is_div;
              // A zero divisor keeps the all-ones quotient unsigned regardless of signs.
              neg_main <= (sign_a ^ sign_b) && !(is_div && (op_b == '0));
              neg_rem  <= sign_a;
              count    <= CW'(N);
              state    <= RUN;
`ifdef MIPS_MULDIV_FAST_MULT_EN
              if (is_mul) begin
                {acc, mq} <= fast_prod;
                state     <= FIXUP;
              end
`endif
            end
          end
        end
        RUN: begin
          acc   <= acc_chain[STEPS_PER_CYCLE];
          mq    <= mq_chain[STEPS_PER_CYCLE];
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          if (div_mode) begin
            hi <= rem;
            lo <= quot;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
